// File: rtl/spram_share_arbiter.sv
// Shares one single-port registered-input RAM between requesters A and B, presented as a pseudo dual-port memory.
// Define SPRAM_ARB_FIXED_PRIO_EN for fixed A-over-B priority; the default is round-robin.
module spram_share_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_ACK} state_t;

  state_t              state_q;
  logic                owner_q;   // 0 = A, 1 = B
  logic                we_q;
  logic                a_ack_q, b_ack_q;
  logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;
  logic [ADDR_W-1:0]   ram_address_q;
  logic [DATA_W-1:0]   ram_data_q;
  logic                ram_wren_q;
`ifndef SPRAM_ARB_FIXED_PRIO_EN
  logic                last_grant_q;  // 0 = A, 1 = B
`endif

  logic                grant_b_d;
  logic                win_we_d;
  logic [ADDR_W-1:0]   win_addr_d;
  logic [DATA_W-1:0]   win_wdata_d;

  always_comb begin
`ifdef SPRAM_ARB_FIXED_PRIO_EN
    grant_b_d = b_req & ~a_req;
`else
    // On a tie B wins only if A was granted last.
    grant_b_d = b_req & (~a_req | ~last_grant_q);
`endif
    win_we_d    = grant_b_d ? b_we    : a_we;
    win_addr_d  = grant_b_d ? b_addr  : a_addr;
    win_wdata_d = grant_b_d ? b_wdata : a_wdata;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= S_IDLE;
      owner_q       <= 1'b0;
      we_q          <= 1'b0;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
`ifndef SPRAM_ARB_FIXED_PRIO_EN
      last_grant_q  <= 1'b1;
`endif
    end else begin
      // NOTE: acks default low here so each one is a single-cycle pulse set only on entry to S_ACK.
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (a_req || b_req) begin
            ram_address_q <= win_addr_d;
            ram_data_q    <= win_wdata_d;
            ram_wren_q    <= win_we_d;
            owner_q       <= grant_b_d;
            we_q          <= win_we_d;
`ifndef SPRAM_ARB_FIXED_PRIO_EN
            last_grant_q  <= grant_b_d;
`endif
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ram_wren_q <= 1'b0;
          if (we_q) begin
            a_ack_q <= ~owner_q;
            b_ack_q <= owner_q;
            state_q <= S_ACK;
          end else begin
            state_q <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (owner_q) b_rdata_q <= ram_q;
          else         a_rdata_q <= ram_q;
          a_ack_q <= ~owner_q;
          b_ack_q <= owner_q;
          state_q <= S_ACK;
        end
        S_ACK:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_spram_share_arbiter.sv
// Directed bench for spram_share_arbiter with a behavioural registered-input 32x4 RAM.
module tb_spram_share_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [4:0] a_addr = '0, b_addr = '0;
  logic [3:0] a_wdata = '0, b_wdata = '0;
  logic       a_ack, b_ack, ram_wren, busy;
  logic [3:0] a_rdata, b_rdata, ram_data;
  logic [3:0] ram_q;
  logic [4:0] ram_address;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  spram_share_arbiter #(.ADDR_W(5), .DATA_W(4)) dut (
    .CLOCK_50(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ramlpm model: address/data/wren registered at the edge, q valid the following cycle.
  logic [3:0] mem [32];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request in the current (IDLE) cycle, wait for its ack, drop req the cycle after.
  task automatic run(input logic port_b, input logic we, input logic [4:0] addr,
                     input logic [3:0] wdata, input int exp_lat, input string tag);
    int start;
    int lat;
    lat = -1;
    if (port_b) begin b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1; end
    else        begin a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1; end
    start = cyc;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (port_b ? b_ack : a_ack) begin
        lat = cyc - start;
        break;
      end
    end
    tick();
    a_req = 1'b0;
    b_req = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  int         start_c, a_c, b_c, n, a_pulses;
  logic       b_early;
  logic [7:0] order;

  initial begin
    // Reset state
    tick(); tick();
    @(negedge clk);
    check("reset outputs", 32'({a_ack, b_ack, a_rdata, b_rdata, ram_address, ram_data, ram_wren, busy}), 32'd0);
    tick();
    reset = 1'b0;

    // A write then read of address 3
    run(1'b0, 1'b1, 5'd3, 4'hA, 2, "A wr3");
    run(1'b0, 1'b0, 5'd3, 4'h0, 3, "A rd3");
    check("A rd3 data", 32'(a_rdata), 32'hA);

    // Contention after reset: A write 5<-7, B read 5 in the same cycle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_we = 1'b1; a_addr = 5'd5; a_wdata = 4'h7; a_req = 1'b1;
    b_we = 1'b0; b_addr = 5'd5; b_req = 1'b1;
    start_c = cyc; a_c = -100; b_c = -100; b_early = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b_ack) b_early = 1'b1;
      if (a_ack) begin a_c = cyc; break; end
    end
    tick();
    a_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b_ack) begin b_c = cyc; break; end
    end
    tick();
    b_req = 1'b0;
    check("contention B not first", 32'(b_early), 32'd0);
    check("contention A latency", 32'(a_c - start_c), 32'd2);
    // B is sampled in the IDLE cycle after a_ack, then takes the 3-cycle read latency.
    check("contention B after A", 32'(b_c - a_c), 32'd4);
    check("contention B data", 32'(b_rdata), 32'h7);

    // Fairness: both hold continuous reads for 8 grants
    a_we = 1'b0; a_addr = 5'd3; a_req = 1'b1;
    b_we = 1'b0; b_addr = 5'd5; b_req = 1'b1;
    n = 0; order = '0;
    for (int i = 0; i < 60 && n < 8; i++) begin
      @(negedge clk);
      if (a_ack)      begin order[n] = 1'b0; n++; end
      else if (b_ack) begin order[n] = 1'b1; n++; end
    end
    tick();
    a_req = 1'b0;
    b_req = 1'b0;
`ifdef SPRAM_ARB_FIXED_PRIO_EN
    check("fairness grant count", 32'(n), 32'd8);
    check("fixed prio all A", 32'(order), 32'h00);
`else
    check("fairness grant count", 32'(n), 32'd8);
    check("fairness alternation", 32'(order), 32'hAA);
    check("fairness B data", 32'(b_rdata), 32'h7);
`endif
    check("fairness A data", 32'(a_rdata), 32'hA);

    // Address boundary on port B
    run(1'b1, 1'b1, 5'd31, 4'hF, 2, "B wr31");
    run(1'b1, 1'b1, 5'd0,  4'h1, 2, "B wr0");
    run(1'b1, 1'b0, 5'd31, 4'h0, 3, "B rd31");
    check("B rd31 data", 32'(b_rdata), 32'hF);
    run(1'b1, 1'b0, 5'd0,  4'h0, 3, "B rd0");
    check("B rd0 data", 32'(b_rdata), 32'h1);

    // Reset during CAPTURE of an A read
    a_we = 1'b0; a_addr = 5'd3; a_req = 1'b1;
    tick();                 // ISSUE
    tick();                 // CAPTURE
    @(negedge clk);
    check("busy in capture", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_req = 1'b0;
    @(negedge clk);
    check("post-reset busy", 32'(busy), 32'd0);
    check("post-reset a_rdata", 32'(a_rdata), 32'd0);
    check("post-reset b_rdata", 32'(b_rdata), 32'd0);
    a_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (a_ack) a_pulses++;
      @(negedge clk);
    end
    check("aborted read no ack", 32'(a_pulses), 32'd0);
    tick();
    run(1'b0, 1'b0, 5'd3, 4'h0, 3, "A reissue rd3");
    check("A reissue data", 32'(a_rdata), 32'hA);

    // Isolation: B access leaves a_rdata untouched
    run(1'b0, 1'b1, 5'd2, 4'h6, 2, "A wr2");
    run(1'b1, 1'b1, 5'd9, 4'hC, 2, "B wr9");
    run(1'b0, 1'b0, 5'd2, 4'h0, 3, "A rd2");
    check("A rd2 data", 32'(a_rdata), 32'h6);
    b_we = 1'b0; b_addr = 5'd9; b_req = 1'b1;
    b_c = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("isolation a_rdata", 32'(a_rdata), 32'h6);
      if (b_ack) begin b_c = i; break; end
    end
    tick();
    b_req = 1'b0;
    check("isolation B ack seen", 32'(b_c), 32'd3);
    check("B rd9 data", 32'(b_rdata), 32'hC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
